// File: rtl/sdram_demo_led_pio_if.sv
// Avalon-MM slave bus bundle for the LED output PIO.
interface sdram_demo_led_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/sdram_demo_led_pio.sv
// LED output PIO: data register with atomic set/clear and auto-clearing timed pulses.
// Define SDRAM_DEMO_LED_PIO_READBACK_EN to build the register read mux; otherwise readdata is 0.
module sdram_demo_led_pio #(
    parameter int              WIDTH        = 8,
    parameter int              PULSE_CYCLES = 50000000,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                clk,
    input  logic                reset,
    sdram_demo_led_pio_if.slave bus,
    output logic [WIDTH-1:0]    out_port
);
    localparam int CW = $clog2(PULSE_CYCLES + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] pulse_mask;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] upd_data;
    logic [WIDTH-1:0] kept_mask;
    logic             wr_en;
    logic             expiring;
    logic             unused_bits;

    always_comb begin
        wd        = bus.writedata[WIDTH-1:0];
        wr_en     = bus.chipselect & ~bus.write_n;
        expiring  = (state == BUSY) && (count == '0);
        kept_mask = pulse_mask & ~wd;
        upd_data  = (bus.address == 3'd4) ? (data | wd) : (data & ~wd);
    end

    assign unused_bits = ^bus.writedata;
    assign out_port    = data;

    // Writes take priority over a coinciding expiry; set/clear still lets the
    // untouched mask bits expire on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            data       <= RESET_VALUE;
            pulse_mask <= '0;
            count      <= '0;
        end else if (wr_en && bus.address == 3'd0) begin
            data       <= wd;
            pulse_mask <= '0;
            count      <= '0;
            state      <= IDLE;
        end else if (wr_en && bus.address == 3'd2 && wd != '0) begin
            data       <= data | wd;
            pulse_mask <= pulse_mask | wd;
            count      <= CW'(PULSE_CYCLES - 1);
            state      <= BUSY;
        end else if (wr_en && (bus.address == 3'd4 || bus.address == 3'd5)) begin
            if (expiring) begin
                data       <= upd_data & ~kept_mask;
                pulse_mask <= '0;
                count      <= '0;
                state      <= IDLE;
            end else begin
                data       <= upd_data;
                pulse_mask <= kept_mask;
                if (kept_mask == '0) begin
                    count <= '0;
                    state <= IDLE;
                end else begin
                    count <= count - 1'b1;
                end
            end
        end else if (expiring) begin
            data       <= data & ~pulse_mask;
            pulse_mask <= '0;
            state      <= IDLE;
        end else if (state == BUSY) begin
            count <= count - 1'b1;
        end
    end

`ifdef SDRAM_DEMO_LED_PIO_READBACK_EN
    logic [31:0] rd_next;

    always_comb begin
        rd_next = '0;
        case (bus.address)
            3'd0:    rd_next[WIDTH-1:0] = data;
            3'd2:    rd_next[WIDTH-1:0] = pulse_mask;
            3'd3:    rd_next[0]         = (state == BUSY);
            default: rd_next            = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.readdata <= '0;
        end else if (bus.chipselect && bus.write_n) begin
            bus.readdata <= rd_next;
        end
    end
`else
    assign bus.readdata = 32'h0;
`endif
endmodule

// File: tb/tb_sdram_demo_led_pio.sv
// Self-checking bench for sdram_demo_led_pio: directed vector table, pulse corner cases, random vs model.
module tb_sdram_demo_led_pio;
    localparam int PC = 4;
`ifdef SDRAM_DEMO_LED_PIO_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] out_port;

    sdram_demo_led_pio_if bus ();

    sdram_demo_led_pio #(
        .WIDTH       (8),
        .PULSE_CYCLES(PC),
        .RESET_VALUE (8'hA5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .out_port(out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pulse tracked as an absolute expiry edge index.
    int unsigned m_cyc;
    int unsigned m_end;
    logic [7:0]  m_data;
    logic [7:0]  m_mask;
    logic [31:0] m_rd;

    function automatic logic [31:0] rb(input logic [31:0] v);
        return RB ? v : 32'h0;
    endfunction

    function automatic void model_reset();
        m_cyc  = 0;
        m_end  = 0;
        m_data = 8'hA5;
        m_mask = 8'h00;
        m_rd   = 32'h0;
    endfunction

    function automatic void model_step(input logic [2:0] a, input logic cs, input logic wn,
                                       input logic [31:0] wdf);
        logic [7:0] w;
        bit         wr;
        bit         expire;
        w      = wdf[7:0];
        wr     = cs && !wn;
        expire = (m_mask != 8'h00) && (m_cyc == m_end);
        if (cs && wn) begin
            case (a)
                3'd0:    m_rd = rb({24'h0, m_data});
                3'd2:    m_rd = rb({24'h0, m_mask});
                3'd3:    m_rd = rb({31'h0, (m_mask != 8'h00)});
                default: m_rd = 32'h0;
            endcase
        end
        if (wr && a == 3'd0) begin
            m_data = w;
            m_mask = 8'h00;
        end else if (wr && a == 3'd2 && w != 8'h00) begin
            m_data = m_data | w;
            m_mask = m_mask | w;
            m_end  = m_cyc + PC;
        end else if (wr && (a == 3'd4 || a == 3'd5)) begin
            m_data = (a == 3'd4) ? (m_data | w) : (m_data & ~w);
            m_mask = m_mask & ~w;
            if (expire) begin
                m_data = m_data & ~m_mask;
                m_mask = 8'h00;
            end
        end else if (expire) begin
            m_data = m_data & ~m_mask;
            m_mask = 8'h00;
        end
        m_cyc++;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one bus cycle, clocks it, advances the model, and returns #1 after the edge.
    task automatic apply_stimulus(input logic [2:0] a, input logic cs, input logic wn,
                                  input logic [31:0] wdf);
        bus.address    = a;
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.writedata  = wdf;
        @(posedge clk);
        model_step(a, cs, wn, wdf);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(3'd0, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic check_output(input string name);
        check({name, "_out"}, {24'h0, out_port}, {24'h0, m_data});
        check({name, "_rd"}, bus.readdata, m_rd);
    endtask

    typedef struct {
        string       name;
        logic [2:0]  addr;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic [7:0]  exp_out;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{"rd_data_rst", 3'd0, 1'b1, 1'b1, 32'h0,        8'hA5, 32'h000000A5};
        vecs[1] = '{"wr_data_0f",  3'd0, 1'b1, 1'b0, 32'h0000000F, 8'h0F, 32'h000000A5};
        vecs[2] = '{"outset_30",   3'd4, 1'b1, 1'b0, 32'h00000030, 8'h3F, 32'h000000A5};
        vecs[3] = '{"outclr_03",   3'd5, 1'b1, 1'b0, 32'h00000003, 8'h3C, 32'h000000A5};
        vecs[4] = '{"rd_data_3c",  3'd0, 1'b1, 1'b1, 32'h0,        8'h3C, 32'h0000003C};
        vecs[5] = '{"rd_status",   3'd3, 1'b1, 1'b1, 32'h0,        8'h3C, 32'h00000000};
        vecs[6] = '{"rd_data_2",   3'd0, 1'b1, 1'b1, 32'h0,        8'h3C, 32'h0000003C};
        vecs[7] = '{"wr_addr1",    3'd1, 1'b1, 1'b0, 32'h000000FF, 8'h3C, 32'h0000003C};
        vecs[8] = '{"wr_data_hi",  3'd0, 1'b1, 1'b0, 32'hABCDE1FF, 8'hFF, 32'h0000003C};
        vecs[9] = '{"rd_addr6",    3'd6, 1'b1, 1'b1, 32'h0,        8'hFF, 32'h00000000};

        reset          = 1'b1;
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
        model_reset();
        #1;
        check("rst_out", {24'h0, out_port}, 32'h000000A5);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_rd", bus.readdata, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i].addr, vecs[i].cs, vecs[i].wn, vecs[i].wd);
            check({vecs[i].name, "_out"}, {24'h0, out_port}, {24'h0, vecs[i].exp_out});
            check({vecs[i].name, "_rd"}, bus.readdata, rb(vecs[i].exp_rd));
        end

        // Pulse 81 lasts exactly PC cycles, STATUS tracks it.
        apply_stimulus(3'd0, 1'b1, 1'b0, 32'h00);
        apply_stimulus(3'd2, 1'b1, 1'b0, 32'h81);
        check("pulse_c0", {24'h0, out_port}, 32'h81);
        apply_stimulus(3'd3, 1'b1, 1'b1, 32'h0);
        check("pulse_c1", {24'h0, out_port}, 32'h81);
        check("pulse_busy1", bus.readdata, rb(32'h1));
        apply_stimulus(3'd2, 1'b1, 1'b1, 32'h0);
        check("pulse_c2", {24'h0, out_port}, 32'h81);
        check("pulse_mask_rd", bus.readdata, rb(32'h81));
        idle(1);
        check("pulse_c3", {24'h0, out_port}, 32'h81);
        idle(1);
        check("pulse_end", {24'h0, out_port}, 32'h00);
        apply_stimulus(3'd3, 1'b1, 1'b1, 32'h0);
        check("pulse_busy0", bus.readdata, rb(32'h0));

        // Retrigger extends all mask bits to PC cycles after the second write.
        apply_stimulus(3'd2, 1'b1, 1'b0, 32'h01);
        idle(1);
        apply_stimulus(3'd2, 1'b1, 1'b0, 32'h02);
        check("retrig_both", {24'h0, out_port}, 32'h03);
        idle(3);
        check("retrig_hold", {24'h0, out_port}, 32'h03);
        idle(1);
        check("retrig_end", {24'h0, out_port}, 32'h00);

        // OUTCLEAR on the only pulsing bit ends the pulse.
        apply_stimulus(3'd2, 1'b1, 1'b0, 32'h01);
        apply_stimulus(3'd5, 1'b1, 1'b0, 32'h01);
        check("clr_pulse_out", {24'h0, out_port}, 32'h00);
        apply_stimulus(3'd3, 1'b1, 1'b1, 32'h0);
        check("clr_pulse_busy", bus.readdata, rb(32'h0));

        // DATA write cancels a pulse; no later clear.
        apply_stimulus(3'd2, 1'b1, 1'b0, 32'h08);
        check("cancel_pulse", {24'h0, out_port}, 32'h08);
        apply_stimulus(3'd0, 1'b1, 1'b0, 32'h10);
        idle(6);
        check("cancel_hold", {24'h0, out_port}, 32'h10);

        // DATA write on the expiry edge wins.
        apply_stimulus(3'd0, 1'b1, 1'b0, 32'h00);
        apply_stimulus(3'd2, 1'b1, 1'b0, 32'h04);
        idle(3);
        apply_stimulus(3'd0, 1'b1, 1'b0, 32'h55);
        idle(2);
        check("expiry_data", {24'h0, out_port}, 32'h55);

        // OUTSET on the expiry edge: set bit kept, remaining mask bit cleared.
        apply_stimulus(3'd0, 1'b1, 1'b0, 32'h00);
        apply_stimulus(3'd2, 1'b1, 1'b0, 32'h06);
        idle(3);
        apply_stimulus(3'd4, 1'b1, 1'b0, 32'h02);
        check("expiry_outset", {24'h0, out_port}, 32'h02);
        idle(5);
        check("expiry_outset_hold", {24'h0, out_port}, 32'h02);

        // Zero-mask PULSE write does nothing.
        apply_stimulus(3'd2, 1'b1, 1'b0, 32'h00);
        apply_stimulus(3'd3, 1'b1, 1'b1, 32'h0);
        check("pulse_zero_busy", bus.readdata, rb(32'h0));
        check("pulse_zero_out", {24'h0, out_port}, 32'h02);

        // Reset mid-pulse discards the pulse.
        apply_stimulus(3'd2, 1'b1, 1'b0, 32'hF0);
        idle(1);
        reset = 1'b1;
        #1;
        check("midrst_out", {24'h0, out_port}, 32'hA5);
        check("midrst_rd", bus.readdata, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        idle(6);
        check("midrst_after", {24'h0, out_port}, 32'hA5);

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            logic [2:0]  a;
            logic        cs;
            logic        wn;
            logic [31:0] w;
            a  = 3'($urandom_range(0, 7));
            cs = ($urandom_range(0, 3) != 0);
            wn = 1'($urandom_range(0, 1));
            w  = $urandom();
            if (a == 3'd0 && $urandom_range(0, 2) != 0) cs = 1'b0;
            if ($urandom_range(0, 7) == 0) w[7:0] = 8'h00;
            apply_stimulus(a, cs, wn, w);
            check_output("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end
endmodule
